// File: rtl/mmio_uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_DIV    = 2'd3;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_TX_BUSY   = 2;
  localparam int unsigned ST_RX_VALID  = 3;
  localparam int unsigned ST_RX_OVERRUN = 4;
  localparam int unsigned ST_RX_FRAME  = 5;

  localparam logic [15:0] DIV_MIN = 16'd16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mmio_uart_fifo.sv
// Synchronous FIFO; push ignored when full, pop ignored when empty.
module mmio_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, RX deserialiser with holding register.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_en,
  input  logic [2:0]  write_op,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        read_en,
  input  logic [2:0]  read_op,
  input  logic [31:0] read_addr,
  output logic [31:0] read_data,
  output logic        hit_r,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  logic [15:0] div;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun, rx_frame_err;
  logic        tx_full, tx_empty, tx_busy, pop;
  logic [7:0]  fifo_data;
  logic [$clog2(TX_DEPTH):0] tx_count;

  // Store path: byte enables and lane-aligned data for the low half-word.
  logic [3:0]  w_be;
  logic [15:0] w_data;
  logic        push, w1c, div_wr;
  logic [15:0] div_new;

  always_comb begin
    w_be   = '0;
    w_data = 16'(write_data << {write_addr[1:0], 3'b000});
    if (write_en && write_addr[31:4] == BASE_ADDR[31:4]) begin
      case (write_op)
        OP_B: w_be = 4'b0001 << write_addr[1:0];
        OP_H: if (!write_addr[0]) w_be = 4'b0011 << write_addr[1:0];
        OP_W: if (write_addr[1:0] == 2'b00) w_be = 4'b1111;
        default: w_be = '0;
      endcase
    end
  end

  assign push    = write_addr[3:2] == OFF_TXDATA && w_be[0];
  assign w1c     = write_addr[3:2] == OFF_STATUS && w_be[0];
  assign div_wr  = write_addr[3:2] == OFF_DIV && (w_be[0] || w_be[1]);
  assign div_new = {w_be[1] ? w_data[15:8] : div[15:8], w_be[0] ? w_data[7:0] : div[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div <= DIV_RESET;
    else if (div_wr) div <= (div_new < DIV_MIN) ? DIV_MIN : div_new;
  end

  // Load path
  logic [31:0] r_word, r_shift;
  logic        r_ok, rd_clear;

  assign hit_r = read_en && read_addr[31:4] == BASE_ADDR[31:4];

  always_comb begin
    r_word = '0;
    case (read_addr[3:2])
      OFF_RXDATA: r_word[7:0] = rx_byte;
      OFF_STATUS: begin
        r_word[ST_TX_FULL]    = tx_full;
        r_word[ST_TX_EMPTY]   = tx_empty;
        r_word[ST_TX_BUSY]    = tx_busy;
        r_word[ST_RX_VALID]   = rx_valid;
        r_word[ST_RX_OVERRUN] = rx_overrun;
        r_word[ST_RX_FRAME]   = rx_frame_err;
      end
      OFF_DIV: r_word[15:0] = div;
      default: r_word = '0;
    endcase
    r_shift   = r_word >> {read_addr[1:0], 3'b000};
    read_data = '0;
    r_ok      = 1'b0;
    if (hit_r) begin
      case (read_op)
        OP_B:  begin r_ok = 1'b1; read_data = {{24{r_shift[7]}}, r_shift[7:0]}; end
        OP_BU: begin r_ok = 1'b1; read_data = {24'b0, r_shift[7:0]}; end
        OP_H:  if (!read_addr[0]) begin r_ok = 1'b1; read_data = {{16{r_shift[15]}}, r_shift[15:0]}; end
        OP_HU: if (!read_addr[0]) begin r_ok = 1'b1; read_data = {16'b0, r_shift[15:0]}; end
        OP_W:  if (read_addr[1:0] == 2'b00) begin r_ok = 1'b1; read_data = r_shift; end
        default: r_ok = 1'b0;
      endcase
    end
  end

  assign rd_clear = r_ok && read_addr[3:2] == OFF_RXDATA;

  mmio_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(w_data[7:0]), .pop(pop),
    .pop_data(fifo_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // TX serialiser
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_tick;

  assign tx_tick = tx_cnt == tx_div - 16'd1;
  assign tx_busy = tx_state != TX_IDLE;
  assign pop     = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_RESET;
      tx_shift <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (pop) begin
          tx_state <= TX_START; tx_shift <= fifo_data; tx_div <= div;
          tx_cnt <= '0; uart_tx <= 1'b0;
        end
        TX_START: if (tx_tick) begin
          tx_state <= TX_DATA; tx_cnt <= '0; tx_bit <= '0; uart_tx <= tx_shift[0];
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_DATA: if (tx_tick) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP; uart_tx <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1; uart_tx <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_STOP: if (tx_tick) begin
          tx_cnt <= '0;
          if (pop) begin
            tx_state <= TX_START; tx_shift <= fifo_data; tx_div <= div; uart_tx <= 1'b0;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
      endcase
    end
  end

  // RX deserialiser
  rx_state_t   rx_state;
  logic [1:0]  rx_sync;
  logic        rx_prev, rx_s, rx_tick, rx_half, rx_done, rx_ferr;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;

  assign rx_s    = rx_sync[1];
  assign rx_tick = rx_cnt == rx_div - 16'd1;
  assign rx_half = rx_cnt == (rx_div >> 1) - 16'd1;
  assign rx_done = rx_state == RX_STOP && rx_tick && rx_s;
  assign rx_ferr = rx_state == RX_STOP && rx_tick && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_RESET;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s) begin
          rx_state <= RX_START; rx_cnt <= '0; rx_div <= div;
        end
        RX_START: if (rx_half) begin
          rx_cnt <= '0; rx_bit <= '0;
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_tick) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_tick) begin
          rx_cnt <= '0; rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  // A byte landing in the same cycle as an RXDATA read replaces it without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_clear) rx_valid <= 1'b0;
      if (rx_done && rx_valid && !rd_clear) rx_overrun <= 1'b1;
      else if (w1c && w_data[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
      if (rx_ferr) rx_frame_err <= 1'b1;
      else if (w1c && w_data[ST_RX_FRAME]) rx_frame_err <= 1'b0;
    end
  end

  assign irq = rx_valid || rx_overrun;

  logic unused_ok;
  assign unused_ok = &{1'b0, tx_count};

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register map, TX framing, RX framing and flags.
module tb_mmio_uart;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [2:0]  write_op = 3'b000;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic        read_en = 1'b0;
  logic [2:0]  read_op = 3'b000;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data;
  logic        hit_r;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        irq;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_RX = 32'h1000_0004;
  localparam logic [31:0] A_ST = 32'h1000_0008;
  localparam logic [31:0] A_DV = 32'h1000_000C;

  always #5 clk = ~clk;

  mmio_uart #(.BASE_ADDR(32'h1000_0000), .TX_DEPTH(8), .DIV_RESET(16'd868)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_op(write_op),
    .write_addr(write_addr), .write_data(write_data), .read_en(read_en),
    .read_op(read_op), .read_addr(read_addr), .read_data(read_data),
    .hit_r(hit_r), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_en = 1'b1; write_op = op; write_addr = addr; write_data = data;
    @(posedge clk);
    #1 write_en = 1'b0;
  endtask

  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] exp);
    @(negedge clk);
    read_en = 1'b1; read_op = op; read_addr = addr;
    #1 check(tag, read_data, exp);
    @(posedge clk);
    #1 read_en = 1'b0;
  endtask

  // Combinational read with no clock edge in between.
  task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    read_en = 1'b1; read_op = 3'b010; read_addr = addr;
    #1 check(tag, read_data, exp);
    read_en = 1'b0;
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [9:0] frame;
  logic [9:0] obs;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_hit_idle", {31'b0, hit_r}, 32'd0);
    check("reset_rdata_idle", read_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    load("reset_status", 3'b010, A_ST, 32'h0000_0002);
    load("reset_div", 3'b010, A_DV, 32'd868);
    load("div_lb_byte1", 3'b000, 32'h1000_000D, 32'h0000_0003);
    load("div_lh", 3'b001, A_DV, 32'h0000_0364);
    load("div_lhu_upper", 3'b101, 32'h1000_000E, 32'h0000_0000);
    load("misaligned_lh", 3'b001, 32'h1000_000D, 32'h0000_0000);
    load("misaligned_lw", 3'b010, 32'h1000_000E, 32'h0000_0000);
    load("reserved_op", 3'b011, A_DV, 32'h0000_0000);
    load("txdata_reads_zero", 3'b010, A_TX, 32'h0000_0000);

    @(negedge clk);
    read_en = 1'b1; read_op = 3'b010; read_addr = 32'h2000_0008;
    #1 check("miss_rdata", read_data, 32'd0);
    check("miss_hit", {31'b0, hit_r}, 32'd0);
    read_addr = A_ST;
    #1 check("window_hit", {31'b0, hit_r}, 32'd1);
    read_en = 1'b0;

    store(3'b010, A_DV, 32'd5);
    load("div_clamped", 3'b010, A_DV, 32'd16);
    store(3'b001, A_DV, 32'h0000_0040);
    load("div_sh", 3'b010, A_DV, 32'd64);
    store(3'b010, A_DV, 32'h0000_0010);
    load("div_16", 3'b010, A_DV, 32'd16);

    store(3'b001, 32'h1000_0001, 32'h41);
    store(3'b000, 32'h1000_0001, 32'h42);
    store(3'b010, 32'h1000_0002, 32'h43);
    peek("ignored_stores", A_ST, 32'h0000_0002);

    // Single 0xA5 frame, sampled mid-bit.
    frame = {1'b1, 8'hA5, 1'b0};
    store(3'b000, A_TX, 32'hFFFF_FFA5);
    wait_clks(9);
    peek("tx_busy_status", A_ST, 32'h0000_0006);
    for (int j = 0; j < 10; j++) begin
      if (j != 0) wait_clks(16);
      check($sformatf("a5_bit%0d", j), {31'b0, uart_tx}, {31'b0, frame[j]});
    end
    wait_clks(10);
    peek("tx_idle_after", A_ST, 32'h0000_0002);

    // Nine back-to-back pushes, tenth dropped.
    for (int k = 0; k < 10; k++) store(3'b000, A_TX, k);
    peek("fifo_full", A_ST, 32'h0000_0005);
    for (int k = 0; k < 9; k++) begin
      frame = {1'b1, 8'(k), 1'b0};
      for (int j = 0; j < 10; j++) begin
        if (!(k == 0 && j == 0)) wait_clks(16);
        obs[j] = uart_tx;
      end
      check($sformatf("b2b_frame%0d", k), {22'b0, obs}, {22'b0, frame});
    end
    wait_clks(16);
    peek("b2b_drained", A_ST, 32'h0000_0002);
    check("b2b_line_idle", {31'b0, uart_tx}, 32'd1);

    // RX
    send_rx(8'h3C, 1'b1);
    wait_clks(1);
    peek("rx_valid_status", A_ST, 32'h0000_000A);
    check("rx_irq", {31'b0, irq}, 32'd1);
    load("rx_lbu", 3'b100, A_RX, 32'h0000_003C);
    peek("rx_cleared", A_ST, 32'h0000_0002);
    check("rx_irq_clear", {31'b0, irq}, 32'd0);

    send_rx(8'hF0, 1'b1);
    load("rx_lb_sext", 3'b000, A_RX, 32'hFFFF_FFF0);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wait_clks(1);
    peek("overrun_status", A_ST, 32'h0000_001A);
    load("overrun_byte", 3'b100, A_RX, 32'h0000_0022);
    peek("overrun_sticky", A_ST, 32'h0000_0012);
    check("overrun_irq", {31'b0, irq}, 32'd1);
    store(3'b010, A_ST, 32'h0000_0010);
    peek("overrun_w1c", A_ST, 32'h0000_0002);

    send_rx(8'h55, 1'b1);
    send_rx(8'h66, 1'b0);
    wait_clks(1);
    peek("frame_err_status", A_ST, 32'h0000_002A);
    load("frame_err_keeps", 3'b100, A_RX, 32'h0000_0055);
    store(3'b000, A_ST, 32'h0000_0020);
    peek("frame_err_w1c", A_ST, 32'h0000_0002);

    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    wait_clks(20);
    peek("glitch_status", A_ST, 32'h0000_0002);
    send_rx(8'h81, 1'b1);
    load("after_glitch_byte", 3'b100, A_RX, 32'h0000_0081);

    // Reset in the middle of data bit 0 of a 0x00 frame.
    store(3'b000, A_TX, 32'h00);
    store(3'b000, A_TX, 32'h00);
    wait_clks(24);
    check("tx_data_bit_low", {31'b0, uart_tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tx", {31'b0, uart_tx}, 32'd1);
    peek("reset_fifo_empty", A_ST, 32'h0000_0002);
    @(negedge clk) rst_n = 1'b1;
    load("reset_div_again", 3'b010, A_DV, 32'd868);
    wait_clks(4);
    check("post_reset_idle", {31'b0, uart_tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
